// File: rtl/fifo_arb_pkg.sv
// Shared constants for the two-writer FIFO write arbiter: state encoding and default widths.
package fifo_arb_pkg;

    localparam int unsigned FBITS_DEF  = 8;
    localparam int unsigned PWIDTH_DEF = 3;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant and the pointer to favour next.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       ptr,
    output logic [1:0] gnt_c,
    output logic       next_ptr_c
);

    always_comb begin
        gnt_c      = 2'b00;
        next_ptr_c = ptr;
        if (enable) begin
            case (req)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = ptr ? 2'b10 : 2'b01;
                default: gnt_c = 2'b00;
            endcase
        end
        // The writer that was just served yields priority to the other one.
        if (gnt_c[0]) begin
            next_ptr_c = 1'b1;
        end else if (gnt_c[1]) begin
            next_ptr_c = 1'b0;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Shares one FIFO storage block between two writers and one reader; tracks occupancy and sequences clear.
// Optional almost-full throttling of writer 1 is enabled with FIFO_WR_ARB_AFULL_EN.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned fbits  = FBITS_DEF,
    parameter int unsigned pwidth = PWIDTH_DEF,
    parameter int unsigned fdepth = 1 << pwidth
`ifdef FIFO_WR_ARB_AFULL_EN
    ,
    parameter int unsigned afull_lvl = fdepth - 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0,
    input  logic [fbits-1:0]  data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [fbits-1:0]  data1,
    output logic              gnt1,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [pwidth:0]   count,
    output logic              empty,
    output logic              full,
`ifdef FIFO_WR_ARB_AFULL_EN
    output logic              afull,
`endif
    output logic              clr_fifo,
    output logic              wr_fifo,
    output logic              rd_fifo,
    output logic [fbits-1:0]  wr_data
);

    localparam int unsigned CW = pwidth + 1;
    localparam logic [pwidth:0] DEPTH_C = CW'(fdepth);
`ifdef FIFO_WR_ARB_AFULL_EN
    localparam logic [pwidth:0] AFULL_C = CW'(afull_lvl);
`endif

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            ptr_nxt;
    logic [1:0]      arb_req;
    logic [1:0]      arb_gnt;
    logic            arb_en;
    logic            wr_acc;
    logic [pwidth:0] count_nxt;

    // Writer 1 is held off once almost full so writer 0 keeps the last slots.
`ifdef FIFO_WR_ARB_AFULL_EN
    assign arb_req = {req1 & ~afull, req0};
`else
    assign arb_req = {req1, req0};
`endif

    assign arb_en = (state == ST_RUN) & ~full & ~flush;

    rr_arb2 u_rr_arb2 (
        .req        (arb_req),
        .enable     (arb_en),
        .ptr        (rr_ptr),
        .gnt_c      (arb_gnt),
        .next_ptr_c (ptr_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a clear always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FLUSH: state_nxt = ST_RUN;
            ST_RUN:   if (flush) state_nxt = ST_FLUSH;
            default:  state_nxt = ST_FLUSH;
        endcase
    end

    // Handshake outputs, valid only while running and not flushing.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        rd_ack = 1'b0;
        if ((state == ST_RUN) && !flush) begin
            gnt0   = arb_gnt[0];
            gnt1   = arb_gnt[1];
            rd_ack = rd_req & ~empty;
        end
    end

    assign wr_acc = gnt0 | gnt1;

    // Occupancy: a simultaneous write and read cancel out.
    always_comb begin
        count_nxt = count;
        if ((state == ST_RUN) && flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_ack) begin
            count_nxt = count + CW'(1);
        end else if (!wr_acc && rd_ack) begin
            count_nxt = count - CW'(1);
        end
    end

    // Registered status and storage-side strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rr_ptr   <= 1'b0;
            clr_fifo <= 1'b1;
            wr_fifo  <= 1'b0;
            rd_fifo  <= 1'b0;
            wr_data  <= '0;
        end else begin
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == DEPTH_C);
            rr_ptr   <= ptr_nxt;
            clr_fifo <= (state_nxt == ST_FLUSH);
            wr_fifo  <= wr_acc;
            rd_fifo  <= rd_ack;
            if (gnt0) begin
                wr_data <= data0;
            end else if (gnt1) begin
                wr_data <= data1;
            end
        end
    end

`ifdef FIFO_WR_ARB_AFULL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            afull <= 1'b0;
        end else begin
            afull <= (count_nxt >= AFULL_C);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with an occupancy/turn-taking reference model checked every cycle.
module tb_fifo_wr_arb;

    localparam int FD  = 8;
    localparam int AFL = 6;

    logic       clk = 1'b0;
    logic       rst, flush, req0, req1, rd_req;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, rd_ack, empty, full, clr_fifo, wr_fifo, rd_fifo;
    logic [3:0] count;
    logic [7:0] wr_data;
`ifdef FIFO_WR_ARB_AFULL_EN
    logic       afull;
`endif

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .fbits  (8),
        .pwidth (3)
`ifdef FIFO_WR_ARB_AFULL_EN
        ,
        .afull_lvl (AFL)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .req0     (req0),
        .data0    (data0),
        .gnt0     (gnt0),
        .req1     (req1),
        .data1    (data1),
        .gnt1     (gnt1),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .count    (count),
        .empty    (empty),
        .full     (full),
`ifdef FIFO_WR_ARB_AFULL_EN
        .afull    (afull),
`endif
        .clr_fifo (clr_fifo),
        .wr_fifo  (wr_fifo),
        .rd_fifo  (rd_fifo),
        .wr_data  (wr_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: whether running, how many words held, whose turn on a tie, pending strobes.
    bit         m_run   = 1'b0;
    int         m_count = 0;
    int         m_turn  = 0;
    bit         m_wp    = 1'b0;
    bit         m_rp    = 1'b0;
    logic [7:0] m_wv    = 8'h00;

    logic obs_g0, obs_g1, obs_rd;
    logic [15:0] gpat;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit fl, input bit q0, input bit q1, input bit rq,
                        input logic [7:0] d0, input logic [7:0] d1);
        bit allow, r1e, e0, e1, erd;
        rst = r; flush = fl; req0 = q0; req1 = q1; rd_req = rq; data0 = d0; data1 = d1;
        #1;
        allow = m_run && (m_count < FD) && !fl;
`ifdef FIFO_WR_ARB_AFULL_EN
        r1e = q1 && (m_count < AFL);
`else
        r1e = q1;
`endif
        e0  = allow && q0 && (!r1e || m_turn == 0);
        e1  = allow && r1e && (!q0 || m_turn == 1);
        erd = m_run && !fl && rq && (m_count > 0);
        obs_g0 = gnt0; obs_g1 = gnt1; obs_rd = rd_ack;
        chk("gnt0",     32'(gnt0),     32'(e0));
        chk("gnt1",     32'(gnt1),     32'(e1));
        chk("rd_ack",   32'(rd_ack),   32'(erd));
        chk("count",    32'(count),    32'(m_count));
        chk("empty",    32'(empty),    32'(m_count == 0));
        chk("full",     32'(full),     32'(m_count == FD));
        chk("clr_fifo", 32'(clr_fifo), 32'(!m_run));
        chk("wr_fifo",  32'(wr_fifo),  32'(m_wp));
        chk("rd_fifo",  32'(rd_fifo),  32'(m_rp));
        chk("wr_data",  32'(wr_data),  32'(m_wv));
`ifdef FIFO_WR_ARB_AFULL_EN
        chk("afull",    32'(afull),    32'(m_count >= AFL));
`endif
        if (r) begin
            m_run = 1'b0; m_count = 0; m_turn = 0; m_wp = 1'b0; m_rp = 1'b0; m_wv = 8'h00;
        end else begin
            if (e0) begin m_turn = 1; m_wv = d0; end
            else if (e1) begin m_turn = 0; m_wv = d1; end
            m_wp = e0 | e1;
            m_rp = erd;
            if (m_run && fl) begin
                m_count = 0; m_run = 1'b0;
            end else begin
                m_count = m_count + int'(e0 | e1) - int'(erd);
                m_run = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        @(posedge clk);
        #1;
        // Reset held two cycles, then release into the single clear cycle.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("lit_rst_clr",   32'(clr_fifo), 32'd1);
        chk("lit_rst_empty", 32'(empty),    32'd1);
        step(0, 0, 0, 0, 0, 8'h00, 8'h00);
        chk("lit_run_clr",   32'(clr_fifo), 32'd0);
        chk("lit_run_count", 32'(count),    32'd0);

        // Both writers compete: grants must alternate starting with writer 0.
        gpat = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1, 0, 8'hA0, 8'hB0);
            if (i < 8) gpat = {gpat[13:0], obs_g1, obs_g0};
        end
        chk("lit_fill_order", 32'(gpat),  32'h6666);
        chk("lit_fill_count", 32'(count), 32'd8);
        chk("lit_fill_full",  32'(full),  32'd1);
        chk("lit_full_gnt",   32'(obs_g0 | obs_g1), 32'd0);

        // Full: the read goes through but the write waits one cycle.
        step(0, 0, 1, 0, 1, 8'hA1, 8'h00);
        chk("lit_full_rd",  32'(obs_rd), 32'd1);
        chk("lit_full_g0",  32'(obs_g0), 32'd0);
        chk("lit_full_cnt", 32'(count),  32'd7);
        step(0, 0, 1, 0, 1, 8'hA2, 8'h00);
        chk("lit_full2_g0",  32'(obs_g0), 32'd1);
        chk("lit_full2_cnt", 32'(count),  32'd7);

        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 8'h00, 8'h00);
        chk("lit_drain_empty", 32'(empty), 32'd1);

        // Empty: the write goes through but the read waits one cycle.
        step(0, 0, 0, 1, 1, 8'h00, 8'hB1);
        chk("lit_empty_g1", 32'(obs_g1), 32'd1);
        chk("lit_empty_rd", 32'(obs_rd), 32'd0);
        step(0, 0, 0, 1, 1, 8'h00, 8'hB2);
        chk("lit_empty2_rd",  32'(obs_rd), 32'd1);
        chk("lit_empty2_cnt", 32'(count),  32'd1);

        // Flush at count 5 with writer 0 requesting.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 8'(8'h10 + i), 8'h00);
        chk("lit_pre_flush", 32'(count), 32'd5);
        step(0, 1, 1, 0, 0, 8'h20, 8'h00);
        chk("lit_flush_g0",  32'(obs_g0),   32'd0);
        chk("lit_flush_clr", 32'(clr_fifo), 32'd1);
        chk("lit_flush_cnt", 32'(count),    32'd0);
        step(0, 0, 1, 0, 0, 8'h21, 8'h00);
        chk("lit_clr_g0", 32'(obs_g0), 32'd0);
        step(0, 0, 1, 0, 0, 8'h22, 8'h00);
        chk("lit_resume_g0", 32'(obs_g0), 32'd1);

        // Mixed traffic from a fixed pattern table.
        for (int i = 0; i < 24; i++) begin
            logic [4:0] pat;
            pat = 5'(i * 7 + 3);
            step(0, (i % 11) == 5, pat[0], pat[1], pat[2] | pat[3], 8'(i), 8'(8'h80 + i));
        end

        // Clear, then writer 1 alone.
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 8'h00, 8'(8'hC0 + i));
`ifdef FIFO_WR_ARB_AFULL_EN
        chk("lit_afull_cnt", 32'(count),  32'd6);
        chk("lit_afull",     32'(afull),  32'd1);
        chk("lit_afull_g1",  32'(obs_g1), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 8'(8'hD0 + i), 8'hCF);
        chk("lit_afull_w0", 32'(count), 32'd8);
`else
        chk("lit_w1_fill", 32'(count), 32'd8);
`endif
        chk("lit_end_full", 32'(full), 32'd1);

        // Reset mid-operation with traffic present.
        step(0, 0, 0, 0, 1, 8'h00, 8'h00);
        step(1, 0, 1, 1, 1, 8'hE0, 8'hE1);
        step(0, 0, 1, 1, 1, 8'hE2, 8'hE3);
        step(0, 0, 1, 1, 1, 8'hE4, 8'hE5);
        step(0, 0, 0, 0, 0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Controller that shares one FIFO storage block between two write requesters and one reader.
- Round-robin arbitration of writers, occupancy tracking (count/empty/full), and sequencing of the FIFO's synchronous clear.
- Drives the storage block's clr_fifo, wr_fifo, rd_fifo and data_in from registered outputs; sits between producer logic and the buffer.

Parameters:
- fbits, 8, data width in bits
- pwidth, 3, address/pointer width of the controlled FIFO
- fdepth, 1<<pwidth, FIFO capacity in entries (8)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  request to empty the FIFO (single-cycle pulse or level)
- req0  in  1  writer 0 has a word
- data0  in  fbits  writer 0 word
- gnt0  out  1  writer 0 word accepted this cycle
- req1  in  1  writer 1 has a word
- data1  in  fbits  writer 1 word
- gnt1  out  1  writer 1 word accepted this cycle
- rd_req  in  1  consumer wants a word
- rd_ack  out  1  read issued this cycle
- count  out  pwidth+1  current occupancy, 0..fdepth
- empty  out  1  count==0
- full  out  1  count==fdepth
- clr_fifo  out  1  to storage: synchronous clear
- wr_fifo  out  1  to storage: write strobe
- rd_fifo  out  1  to storage: read strobe
- wr_data  out  fbits  to storage: write data

Behaviour:
- FSM states: FLUSH, RUN.
- Reset (rst=1 at edge):
  - state=FLUSH, count=0, empty=1, full=0, rr_ptr=0.
  - clr_fifo=1, wr_fifo=0, rd_fifo=0, wr_data=0.
- FLUSH:
  - Lasts exactly 1 cycle, then RUN.
  - clr_fifo=1 for that cycle; gnt0/gnt1/rd_ack=0.
- RUN:
  - flush=1 at edge -> next state FLUSH, count<=0; no write or read is accepted that cycle (gnts forced 0).
- Grants are combinational from registered state and current req, asserted only in RUN with full=0 and flush=0:
  - only one req -> grant it;
  - both req -> grant writer rr_ptr.
- rr_ptr update: after a granted write, rr_ptr <= index of the non-granted writer. Unchanged when there is no grant.
- Accepted write (reqN & gntN):
  - next cycle wr_fifo=1 and wr_data=dataN (1-cycle registered latency);
  - otherwise wr_fifo=0 and wr_data holds its value.
- rd_ack = rd_req & !empty & state==RUN & !flush.
  - rd_fifo registered: rd_fifo=1 the cycle after rd_ack.
- Count:
  - +1 on accepted write, -1 on rd_ack;
  - both in the same cycle -> unchanged;
  - empty and full are registered and recomputed from next count.
- Boundary conditions:
  - full: write blocked even if rd_ack in the same cycle (grants use registered full).
  - empty: read blocked even if write accepted in the same cycle.
  - count never wraps: saturates by construction within 0..fdepth.
- rst or flush mid-operation: a write/read strobe already registered is still emitted the following cycle, coincident with clr_fifo=1. The storage block gives clr priority, so the strobe is harmless.
- clr_fifo=0 in RUN.

Optional Feature:
- Macro: FIFO_WR_ARB_AFULL_EN.
- Enabled:
  - adds parameter afull_lvl (default fdepth-2) and output afull (1 bit), registered, =1 when count>=afull_lvl;
  - afull resets to 0;
  - grants are additionally suppressed when afull=1 and the requesting writer is writer 1 (writer 0 keeps the last slots).
- Disabled: no afull port, no parameter; writers are treated symmetrically.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding constants ST_FLUSH=1'b0, ST_RUN=1'b1;
  - the default pwidth/fbits constants.
- Sub-module rr_arb2:
  - two-requester round-robin arbiter;
  - inputs req[1:0], enable, priority pointer; outputs one-hot gnt[1:0] and next pointer;
  - instantiated once.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> clr_fifo=1 first RUN-preceding cycle, then 0; count=0, empty=1, full=0, gnt0=gnt1=0.
- Both writers request continuously, data0=8'hA0, data1=8'hB0 -> grants alternate 0,1,0,1...; wr_data sequence A0,B0,A0,...; after 8 accepts full=1, gnts=0, count=8.
- Full with rd_req=1 and req0=1: first cycle rd_ack=1 and gnt0=0, count 8->7; next cycle gnt0=1 and rd_ack=1, count stays 7.
- Empty with req1=1 and rd_req=1: gnt1=1, rd_ack=0, count 0->1; next cycle rd_ack=1, gnt1=1, count stays 1.
- count=5, flush=1 for one cycle with req0=1: gnt0=0; next cycle clr_fifo=1, count=0, empty=1; cycle after that, RUN resumes and gnt0=1.
- FIFO_WR_ARB_AFULL_EN defined, afull_lvl=6: fill to 6 -> afull=1; writer 1 alone gets no grant; writer 0 is granted up to count=8.
